// File: rtl/stoch_window_counter_if.sv
// Result handshake between stoch_window_counter and its consumer.
// The producer drives OUT_COUNT/OUT_VALID and the consumer drives OUT_READY.
interface stoch_window_counter_if #(
  parameter int LOGWIN = 8
);
  logic [LOGWIN:0] OUT_COUNT;
  logic            OUT_VALID;
  logic            OUT_READY;

  modport master (
    output OUT_COUNT,
    output OUT_VALID,
    input  OUT_READY
  );

  modport slave (
    input  OUT_COUNT,
    input  OUT_VALID,
    output OUT_READY
  );
endinterface

// File: rtl/stoch_window_counter.sv
// Counts ones of a stochastic bitstream over 2^LOGWIN qualified samples and
// offers each window's count over a valid/ready handshake.
module stoch_window_counter #(
  parameter int LOGWIN     = 8,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic                           CLK,
  input  logic                           INIT,
  input  logic                           IN,
  input  logic                           EN,
  input  logic                           START,
  stoch_window_counter_if.master         out_if,
  output logic                           OVERRUN,
  output logic                           BUSY
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LOGWIN-1:0] SAMP_LAST = {LOGWIN{1'b1}};
  localparam logic [LOGWIN-1:0] SAMP_ZERO = {LOGWIN{1'b0}};
  localparam logic [LOGWIN-1:0] SAMP_ONE  = {{(LOGWIN-1){1'b0}}, 1'b1};
  localparam logic [LOGWIN:0]   ONES_ZERO = {(LOGWIN+1){1'b0}};

  state_t            state_r, state_s;
  logic [LOGWIN-1:0] samp_r, samp_s;
  logic [LOGWIN:0]   ones_r, ones_s;
  logic [LOGWIN:0]   count_r, count_s;
  logic              valid_r, valid_s;
  logic              overrun_r, overrun_s;
  logic              busy_r, busy_s;
  logic [LOGWIN:0]   sum_s;

  // Running total including this cycle's sample; one extra bit avoids wrap at 2^LOGWIN.
  assign sum_s = ones_r + {{LOGWIN{1'b0}}, IN};

  // Next-state, counting, completion and handshake decisions.
  always_comb begin
    state_s   = state_r;
    samp_s    = samp_r;
    ones_s    = ones_r;
    count_s   = count_r;
    overrun_s = overrun_r;
    if (valid_r && out_if.OUT_READY) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
    case (state_r)
      IDLE: begin
        if (START) begin
          state_s = RUN;
          samp_s  = SAMP_ZERO;
          ones_s  = ONES_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (EN && (samp_r == SAMP_LAST)) begin
          // A completion reloads the result even if the old one leaves this edge.
          count_s = sum_s;
          valid_s = 1'b1;
          samp_s  = SAMP_ZERO;
          ones_s  = ONES_ZERO;
          if (valid_r && !out_if.OUT_READY) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun_r;
          end
          if (CONTINUOUS) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end else if (EN) begin
          samp_s = samp_r + SAMP_ONE;
          ones_s = sum_s;
        end else begin
          samp_s = samp_r;
          ones_s = ones_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == RUN);
  end

  // State and output registers, cleared asynchronously by INIT.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_r   <= IDLE;
      samp_r    <= SAMP_ZERO;
      ones_r    <= ONES_ZERO;
      count_r   <= ONES_ZERO;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      samp_r    <= samp_s;
      ones_r    <= ones_s;
      count_r   <= count_s;
      valid_r   <= valid_s;
      overrun_r <= overrun_s;
      busy_r    <= busy_s;
    end
  end

  assign out_if.OUT_COUNT = count_r;
  assign out_if.OUT_VALID = valid_r;
  assign OVERRUN          = overrun_r;
  assign BUSY             = busy_r;

endmodule
